// File: rtl/rr_request_response_router_if.sv
// Request/response bus of the round-robin PLM router: consumer requests, kernel pivots,
// kernel read data and per-consumer responses.
interface rr_request_response_router_if #(
  parameter int unsigned REQ_WIDTH  = 14,
  parameter int unsigned RES_WIDTH  = 9,
  parameter int unsigned NCONSUMERS = 2,
  parameter int unsigned NKERNELS   = 2,
  parameter int unsigned SEL_WIDTH  = $clog2(NCONSUMERS)
);
  logic [REQ_WIDTH-1:0] requests              [NCONSUMERS];
  logic [SEL_WIDTH-1:0] select                [NKERNELS];
  logic [REQ_WIDTH-1:0] selected_requests     [NKERNELS];
  logic [RES_WIDTH-1:0] augmented_plm_outputs [NKERNELS];
  logic [SEL_WIDTH-1:0] response_pivots       [NKERNELS];
  logic [RES_WIDTH-1:0] responses             [NCONSUMERS];

  modport master (
    output requests, select, augmented_plm_outputs, response_pivots,
    input  selected_requests, responses
  );

  modport slave (
    input  requests, select, augmented_plm_outputs, response_pivots,
    output selected_requests, responses
  );
endinterface

// File: rtl/rr_request_response_router.sv
// Routing fabric of the RR PLM scheduler: combinational request mux per kernel and
// registered response mux per consumer (lowest-index matching kernel wins).
module rr_request_response_router #(
  parameter int unsigned REQ_WIDTH  = 14,
  parameter int unsigned RES_WIDTH  = 9,
  parameter int unsigned NCONSUMERS = 2,
  parameter int unsigned NKERNELS   = 2,
  parameter int unsigned SEL_WIDTH  = $clog2(NCONSUMERS)
) (
  input  logic                          clk,
  input  logic                          reset,
  rr_request_response_router_if.slave   bus
);

  logic [RES_WIDTH-1:0] responses_d [NCONSUMERS];
  logic [RES_WIDTH-1:0] responses_q [NCONSUMERS];

  // Request mux; out-of-range pivots yield an all-zero word.
  always_comb begin
    for (int k = 0; k < int'(NKERNELS); k++) begin
      bus.selected_requests[k] = '0;
      for (int c = 0; c < int'(NCONSUMERS); c++) begin
        if (bus.select[k] == SEL_WIDTH'(c)) begin
          bus.selected_requests[k] = bus.requests[c];
        end
      end
    end
  end

  // Response mux; scanning kernels high to low leaves the lowest-index match in place.
  always_comb begin
    for (int c = 0; c < int'(NCONSUMERS); c++) begin
      responses_d[c] = '0;
      for (int k = int'(NKERNELS) - 1; k >= 0; k--) begin
        if (bus.response_pivots[k] == SEL_WIDTH'(c) && bus.augmented_plm_outputs[k][0]) begin
          responses_d[c] = bus.augmented_plm_outputs[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < int'(NCONSUMERS); c++) begin
        responses_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < int'(NCONSUMERS); c++) begin
        responses_q[c] <= responses_d[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < int'(NCONSUMERS); c++) begin
      bus.responses[c] = responses_q[c];
    end
  end

endmodule

// File: tb/tb_rr_request_response_router.sv
// Directed plus randomized bench for rr_request_response_router against a spec-level model;
// a second 3-consumer instance covers out-of-range request pivots.
module tb_rr_request_response_router;

  localparam int unsigned RQW = 14;
  localparam int unsigned RSW = 9;
  localparam int unsigned NC  = 4;
  localparam int unsigned NK  = 2;
  localparam int unsigned SW  = 2;
  localparam int unsigned NC3 = 3;
  localparam int unsigned NK3 = 3;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  rr_request_response_router_if #(.REQ_WIDTH(RQW), .RES_WIDTH(RSW), .NCONSUMERS(NC),
    .NKERNELS(NK), .SEL_WIDTH(SW)) ba ();
  rr_request_response_router_if #(.REQ_WIDTH(RQW), .RES_WIDTH(RSW), .NCONSUMERS(NC3),
    .NKERNELS(NK3), .SEL_WIDTH(SW)) bb ();

  rr_request_response_router #(.REQ_WIDTH(RQW), .RES_WIDTH(RSW), .NCONSUMERS(NC),
    .NKERNELS(NK), .SEL_WIDTH(SW)) dut_a (.clk(clk), .reset(reset), .bus(ba));
  rr_request_response_router #(.REQ_WIDTH(RQW), .RES_WIDTH(RSW), .NCONSUMERS(NC3),
    .NKERNELS(NK3), .SEL_WIDTH(SW)) dut_b (.clk(clk), .reset(reset), .bus(bb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec model: first kernel (by index) that is valid and addressed to consumer c.
  function automatic logic [RSW-1:0] model_resp(input int c);
    for (int k = 0; k < int'(NK); k++) begin
      if (int'(ba.response_pivots[k]) == c && ba.augmented_plm_outputs[k][0] == 1'b1) begin
        return ba.augmented_plm_outputs[k];
      end
    end
    return '0;
  endfunction

  task automatic check_all_resp(input string tag, input logic [RSW-1:0] exp [NC]);
    for (int c = 0; c < int'(NC); c++) begin
      chk($sformatf("%s_resp%0d", tag, c), 32'(ba.responses[c]), 32'(exp[c]));
    end
  endtask

  initial begin
    logic [RSW-1:0] exp_r [NC];
    logic [RQW-1:0] exp_q;

    reset = 1'b0;
    for (int i = 0; i < int'(NC); i++) ba.requests[i] = '0;
    for (int k = 0; k < int'(NK); k++) begin
      ba.select[k] = '0;
      ba.augmented_plm_outputs[k] = '0;
      ba.response_pivots[k] = '0;
    end
    for (int i = 0; i < int'(NC3); i++) bb.requests[i] = '0;
    for (int k = 0; k < int'(NK3); k++) begin
      bb.select[k] = '0;
      bb.augmented_plm_outputs[k] = '0;
      bb.response_pivots[k] = '0;
    end
    #1;
    exp_r = '{default: '0};
    check_all_resp("reset_init", exp_r);

    // Reset held with valid data present: responses stay zero across clocks.
    ba.augmented_plm_outputs[0] = 9'h155;
    ba.response_pivots[0] = 2'd1;
    repeat (3) tick();
    check_all_resp("reset_hold", exp_r);
    reset = 1'b1;
    tick();
    exp_r = '{default: '0};
    exp_r[1] = 9'h155;
    check_all_resp("reset_release", exp_r);

    // Request select.
    for (int i = 0; i < int'(NC); i++) ba.requests[i] = RQW'(14'h100 + i);
    ba.select[0] = 2'd2;
    ba.select[1] = 2'd0;
    #1;
    chk("req_sel0", 32'(ba.selected_requests[0]), 32'h102);
    chk("req_sel1", 32'(ba.selected_requests[1]), 32'h100);
    for (int s0 = 0; s0 < int'(NC); s0++) begin
      for (int s1 = 0; s1 < int'(NC); s1++) begin
        ba.select[0] = SW'(s0);
        ba.select[1] = SW'(s1);
        #1;
        chk($sformatf("req_sweep_k0_s%0d", s0), 32'(ba.selected_requests[0]), 32'h100 + 32'(s0));
        chk($sformatf("req_sweep_k1_s%0d", s1), 32'(ba.selected_requests[1]), 32'h100 + 32'(s1));
      end
    end

    // Single route.
    ba.augmented_plm_outputs[0] = 9'h0AA;
    ba.response_pivots[0] = 2'd3;
    ba.augmented_plm_outputs[1] = 9'h1A5;
    ba.response_pivots[1] = 2'd3;
    tick();
    exp_r = '{default: '0};
    exp_r[3] = 9'h1A5;
    check_all_resp("single_route", exp_r);

    // Invalid gating: value bits of a non-valid output never leak, nothing is held.
    ba.augmented_plm_outputs[0] = 9'h1FE;
    ba.response_pivots[0] = 2'd0;
    ba.augmented_plm_outputs[1] = 9'h000;
    tick();
    exp_r = '{default: '0};
    check_all_resp("invalid_gate", exp_r);

    // Conflict: lowest kernel wins, then split across consumers.
    ba.augmented_plm_outputs[0] = 9'h011;
    ba.response_pivots[0] = 2'd2;
    ba.augmented_plm_outputs[1] = 9'h033;
    ba.response_pivots[1] = 2'd2;
    tick();
    exp_r = '{default: '0};
    exp_r[2] = 9'h011;
    check_all_resp("conflict", exp_r);
    ba.response_pivots[0] = 2'd1;
    tick();
    exp_r = '{default: '0};
    exp_r[1] = 9'h011;
    exp_r[2] = 9'h033;
    check_all_resp("split", exp_r);

    // Async reset between edges clears responses without a clock.
    #2;
    reset = 1'b0;
    #1;
    exp_r = '{default: '0};
    check_all_resp("async_reset", exp_r);
    #1;
    reset = 1'b1;
    tick();
    exp_r[1] = 9'h011;
    exp_r[2] = 9'h033;
    check_all_resp("post_async", exp_r);

    // Randomized traffic on both instances.
    for (int it = 0; it < 200; it++) begin
      for (int i = 0; i < int'(NC); i++) ba.requests[i] = RQW'($urandom);
      for (int k = 0; k < int'(NK); k++) begin
        ba.select[k] = SW'($urandom_range(NC - 1, 0));
        ba.augmented_plm_outputs[k] = RSW'($urandom);
        ba.response_pivots[k] = SW'($urandom_range(NC - 1, 0));
      end
      for (int i = 0; i < int'(NC3); i++) bb.requests[i] = RQW'($urandom);
      for (int k = 0; k < int'(NK3); k++) bb.select[k] = SW'($urandom_range(3, 0));
      #1;
      for (int k = 0; k < int'(NK); k++) begin
        chk($sformatf("rnd_req_a_k%0d", k), 32'(ba.selected_requests[k]),
            32'(ba.requests[ba.select[k]]));
      end
      for (int k = 0; k < int'(NK3); k++) begin
        exp_q = (int'(bb.select[k]) < int'(NC3)) ? bb.requests[bb.select[k]] : '0;
        chk($sformatf("rnd_req_b_k%0d", k), 32'(bb.selected_requests[k]), 32'(exp_q));
      end
      for (int c = 0; c < int'(NC); c++) exp_r[c] = model_resp(c);
      tick();
      check_all_resp("rnd", exp_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_request_response_router.md
Name: rr_request_response_router

Overview:
- Routing fabric of the round-robin PLM scheduler.
- Request side: each scheduling kernel (bank×port) picks one consumer request using its RR pivot. Combinational, equivalent to one request mux per kernel.
- Response side: each consumer collects the PLM read data addressed to it from whichever kernel served it. Equivalent to one response mux per consumer, with a registered output stage.

Parameters:
- REQ_WIDTH, 14: bits per request word {addr, value, wr, valid}; valid is bit 0.
- RES_WIDTH, 9: bits per augmented PLM output/response {value, valid}; valid is bit 0.
- NCONSUMERS, 2: number of consumers (≥2).
- NKERNELS, 2: number of scheduling kernels, NBANKS*NPORTS (≥2).
- SEL_WIDTH, $clog2(NCONSUMERS): width of a consumer index (pivot).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- requests  input  [REQ_WIDTH-1:0] x NCONSUMERS  consumer request words.
- select  input  [SEL_WIDTH-1:0] x NKERNELS  current RR pivot of each kernel.
- selected_requests  output  [REQ_WIDTH-1:0] x NKERNELS  request chosen by each kernel's pivot.
- augmented_plm_outputs  input  [RES_WIDTH-1:0] x NKERNELS  {PLM read data, response-valid}, one per kernel.
- response_pivots  input  [SEL_WIDTH-1:0] x NKERNELS  consumer index each kernel served last cycle.
- responses  output  [RES_WIDTH-1:0] x NCONSUMERS  registered response per consumer.

Behaviour:
- Request path is purely combinational: selected_requests[k] = requests[select[k]].
  - No gating on the valid bit; the full word is passed, valid bit included.
  - If select[k] ≥ NCONSUMERS (non-power-of-2 NCONSUMERS), selected_requests[k] = 0.
  - Unaffected by reset.
- Response match: kernel k matches consumer c when response_pivots[k] == c AND augmented_plm_outputs[k][0] == 1.
- Response selection, computed combinationally per consumer c:
  - If one or more kernels match, take the lowest-index matching kernel k; next = augmented_plm_outputs[k], full word.
  - If none match, next = all zeros, so the valid bit is 0.
  - Several kernels matching the same consumer is legal; lowest index wins, deterministically.
  - A kernel matches at most one consumer per cycle; different consumers can receive from different kernels in the same cycle.
- Response register: responses[c] <= next on every posedge clk.
  - Latency is exactly 1 cycle from augmented_plm_outputs/response_pivots to responses.
- Reset: while reset == 0, all responses are forced to 0 asynchronously, independent of clk. The first capture happens on the first posedge after reset returns to 1. Reset asserted mid-operation clears any pending response.
- Invalid data: value bits of non-valid kernel outputs never reach any consumer; the output is zeroed, not held.
- Handshake: none. No backpressure, no state other than the response registers.
- Widths: the pivot comparison is SEL_WIDTH bits unsigned; consumer index c is truncated to SEL_WIDTH.

Test Plan:
1. Request select, NCONSUMERS=4, NKERNELS=2, requests[i] = 14'h100+i. Set select={2,0} -> selected_requests[0]=14'h102, selected_requests[1]=14'h100, same cycle. Sweep all selects -> always requests[select].
2. Reset. Hold reset=0 with valid kernel data present -> all responses stay 0 across clocks. Release reset -> on the first posedge, responses reflect the inputs.
3. Single route. augmented_plm_outputs[1]=9'h1A5 (valid=1), response_pivots[1]=3, kernel 0 invalid -> after one posedge, responses[3]=9'h1A5 and the other responses are 0.
4. Invalid gating. augmented_plm_outputs[0]=9'h1FE (valid=0), response_pivots[0]=0 -> responses[0]=0 after the clock.
5. Conflict. Kernels 0 and 1 both valid, both pivot=2, data 9'h011/9'h033 -> responses[2]=9'h011. Then kernel 0 pivot=1 -> responses[1]=9'h011 and responses[2]=9'h033 in the same cycle.
6. Async reset mid-stream. Assert reset between clock edges while responses are nonzero -> all responses go to 0 immediately, with no clock edge.
